// File: rtl/frog_pkg.sv
// Shared types and constants for the frog hop controller slice.
package frog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOP,
        COOLDOWN,
        DYING,
        RESPAWN,
        GAME_OVER
    } hop_state_t;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_t;

    localparam int unsigned LIVES_W = 2;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector on the four key levels with up > down > left > right priority.
module key_edge_detect
    import frog_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] keys,         // {right, left, down, up}
    output logic       press_valid,
    output dir_t       press_dir
);

    logic [3:0] hist;
    logic [3:0] press;

    // History resets to all ones so a key held through reset is not seen as a press.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hist <= '1;
        end else begin
            hist <= keys;
        end
    end

    assign press = keys & ~hist;

    always_comb begin
        press_valid = |press;
        press_dir   = UP;
        if (press[0]) begin
            press_dir = UP;
        end else if (press[1]) begin
            press_dir = DOWN;
        end else if (press[2]) begin
            press_dir = LEFT;
        end else if (press[3]) begin
            press_dir = RIGHT;
        end
    end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Turns key presses into fixed-length hops and sequences death, respawn and game over.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int unsigned HOP_TICKS      = 8,
    parameter int unsigned COOLDOWN_TICKS = 4,
    parameter int unsigned DEATH_TICKS    = 60,
    parameter int unsigned LIVES          = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               timer_done,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               collision,
    input  logic               drown,
    input  logic               new_game,
    output logic               left,
    output logic               right,
    output logic               up,
    output logic               down,
    output logic               reset_position,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    localparam logic [7:0] HOP_LAST   = 8'(HOP_TICKS - 1);
    localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_TICKS - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_TICKS - 1);

    hop_state_t state;
    dir_t       dir;
    logic [7:0] tick_cnt;
    logic       press_valid;
    dir_t       press_dir;
    logic       hazard;
    logic       alive;

    key_edge_detect u_keys (
        .CLK         (CLK),
        .RESET       (RESET),
        .keys        ({key_right, key_left, key_down, key_up}),
        .press_valid (press_valid),
        .press_dir   (press_dir)
    );

    assign hazard = collision | drown;
    assign alive  = (state == IDLE) || (state == HOP) || (state == COOLDOWN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            dir      <= UP;
            tick_cnt <= '0;
            lives    <= LIVES_W'(LIVES);
        end else if (alive && hazard) begin
            // Death wins over a press or a hop completing in the same cycle.
            state    <= DYING;
            tick_cnt <= '0;
            lives    <= (lives == '0) ? '0 : lives - LIVES_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (press_valid) begin
                        dir      <= press_dir;
                        tick_cnt <= '0;
                        state    <= HOP;
                    end
                end
                HOP: begin
                    if (timer_done) begin
                        if (tick_cnt == HOP_LAST) begin
                            tick_cnt <= '0;
                            state    <= (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (timer_done) begin
                        if (tick_cnt == COOL_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                DYING: begin
                    if (timer_done) begin
                        if (tick_cnt == DEATH_LAST) begin
                            tick_cnt <= '0;
                            state    <= (lives == '0) ? GAME_OVER : RESPAWN;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                end
                RESPAWN: begin
                    state <= IDLE;
                end
                GAME_OVER: begin
                    if (new_game) begin
                        lives <= LIVES_W'(LIVES);
                        state <= RESPAWN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign up             = (state == HOP) && (dir == UP);
    assign down           = (state == HOP) && (dir == DOWN);
    assign left           = (state == HOP) && (dir == LEFT);
    assign right          = (state == HOP) && (dir == RIGHT);
    assign reset_position = (state == RESPAWN);
    assign game_over      = (state == GAME_OVER);

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed bench for frog_hop_ctrl: vector table for hop/lockout, hand sequences for death, game over and reset.
module tb_frog_hop_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       timer_done;
    logic       key_left, key_right, key_up, key_down;
    logic       collision, drown, new_game;
    logic       left, right, up, down;
    logic       reset_position;
    logic [1:0] lives;
    logic       game_over;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Key and direction vectors use {right, left, down, up}.
    localparam logic [3:0] KU = 4'b0001;
    localparam logic [3:0] KD = 4'b0010;
    localparam logic [3:0] KL = 4'b0100;
    localparam logic [3:0] KR = 4'b1000;
    localparam logic [3:0] K0 = 4'b0000;

    typedef struct {
        logic       td;
        logic [3:0] k;
        logic [3:0] d;
    } vec_t;

    vec_t tbl [0:16];

    frog_hop_ctrl #(
        .HOP_TICKS      (8),
        .COOLDOWN_TICKS (4),
        .DEATH_TICKS    (60),
        .LIVES          (3)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .timer_done     (timer_done),
        .key_left       (key_left),
        .key_right      (key_right),
        .key_up         (key_up),
        .key_down       (key_down),
        .collision      (collision),
        .drown          (drown),
        .new_game       (new_game),
        .left           (left),
        .right          (right),
        .up             (up),
        .down           (down),
        .reset_position (reset_position),
        .lives          (lives),
        .game_over      (game_over)
    );

    always #5 CLK = ~CLK;

    task automatic cycle(input logic td, input logic [3:0] k, input logic col,
                         input logic drn, input logic ng);
        timer_done = td;
        key_up     = k[0];
        key_down   = k[1];
        key_left   = k[2];
        key_right  = k[3];
        collision  = col;
        drown      = drn;
        new_game   = ng;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] d, input logic rp,
                         input logic [1:0] lv, input logic go);
        logic [7:0] act;
        logic [7:0] req;
        act = {right, left, down, up, reset_position, lives, game_over};
        req = {d, rp, lv, go};
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got dirs=%b rp=%b lives=%0d go=%b, required dirs=%b rp=%b lives=%0d go=%b",
                     name, act[7:4], act[3], act[2:1], act[0], d, rp, lv, go);
        end
    endtask

    // Enters DYING by drown (with a simultaneous left press that must lose), then waits out the delay.
    task automatic die_and_wait(input logic [1:0] lv_after, input logic to_game_over);
        cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
        check("pre_drown_idle", K0, 1'b0, lv_after + 2'd1, 1'b0);
        cycle(1'b0, KL, 1'b0, 1'b1, 1'b0);
        check("drown_beats_press", K0, 1'b0, lv_after, 1'b0);
        for (int i = 0; i < 59; i++) begin
            cycle(1'b1, K0, 1'b0, 1'b0, 1'b0);
            if (i == 58) check("drown_dying_end", K0, 1'b0, lv_after, 1'b0);
        end
        cycle(1'b1, K0, 1'b0, 1'b0, 1'b0);
        if (to_game_over) begin
            check("game_over_entry", K0, 1'b0, 2'd0, 1'b1);
        end else begin
            check("drown_respawn", K0, 1'b1, lv_after, 1'b0);
            cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
            check("drown_respawn_one_cycle", K0, 1'b0, lv_after, 1'b0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, K0,      K0};
        tbl[1]  = '{1'b1, KU,      KU};  // tick on the press edge is not counted
        tbl[2]  = '{1'b1, KU,      KU};
        tbl[3]  = '{1'b0, KU,      KU};
        tbl[4]  = '{1'b1, KU,      KU};
        tbl[5]  = '{1'b1, KU | KL, KU};  // left press during hop discarded
        tbl[6]  = '{1'b1, KU,      KU};
        tbl[7]  = '{1'b1, KU,      KU};
        tbl[8]  = '{1'b1, KU,      KU};
        tbl[9]  = '{1'b1, KU,      KU};
        tbl[10] = '{1'b1, KU,      K0};  // eighth tick ends the hop
        tbl[11] = '{1'b1, KU | KL, K0};  // cooldown tick 1, press discarded
        tbl[12] = '{1'b1, KU,      K0};
        tbl[13] = '{1'b1, KU,      K0};
        tbl[14] = '{1'b1, KU | KL, K0};  // fourth tick: still cooldown at this edge
        tbl[15] = '{1'b0, KU,      K0};
        tbl[16] = '{1'b0, KU | KL, KL};  // fresh press in IDLE

        RESET = 1'b1;
        cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
        check("reset_state", K0, 1'b0, 2'd3, 1'b0);
        RESET = 1'b0;

        for (int i = 0; i <= 16; i++) begin
            cycle(tbl[i].td, tbl[i].k, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d", i), tbl[i].d, 1'b0, 2'd3, 1'b0);
        end

        // Finish the left hop and its cooldown.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, KU | KL, 1'b0, 1'b0, 1'b0);
            check($sformatf("left_hop_tick%0d", i), (i < 7) ? KL : K0, 1'b0, 2'd3, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, KU | KL, 1'b0, 1'b0, 1'b0);
        check("left_cooldown_done", K0, 1'b0, 2'd3, 1'b0);

        // Simultaneous down and right rises: down wins.
        cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, KD | KR, 1'b0, 1'b0, 1'b0);
        check("priority_down_over_right", KD, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, KD | KR, 1'b0, 1'b0, 1'b0);
        check("down_hop_done", K0, 1'b0, 2'd3, 1'b0);

        // Death mid-hop at tick 3; hazards and keys in DYING are ignored.
        cycle(1'b0, KU | KD | KR, 1'b0, 1'b0, 1'b0);
        check("up_hop_start", KU, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, KU | KD | KR, 1'b0, 1'b0, 1'b0);
        check("up_hop_tick3", KU, 1'b0, 2'd3, 1'b0);
        cycle(1'b1, KU | KD | KR, 1'b1, 1'b0, 1'b0);
        check("collision_drop", K0, 1'b0, 2'd2, 1'b0);
        for (int i = 0; i < 59; i++) begin
            cycle(1'b1, (i >= 10) ? 4'b1111 : 4'b1011, (i == 5), 1'b0, 1'b0);
            if (i == 58) check("dying_ignores_inputs", K0, 1'b0, 2'd2, 1'b0);
        end
        cycle(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("respawn_pulse", K0, 1'b1, 2'd2, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("respawn_one_cycle", K0, 1'b0, 2'd2, 1'b0);

        // Remaining two deaths lead to game over.
        die_and_wait(2'd1, 1'b0);
        die_and_wait(2'd0, 1'b1);
        cycle(1'b1, K0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, KU, 1'b0, 1'b1, 1'b0);
        check("game_over_ignores", K0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, KU, 1'b0, 1'b0, 1'b1);
        check("new_game_respawn", K0, 1'b1, 2'd3, 1'b0);
        cycle(1'b0, KU, 1'b0, 1'b0, 1'b0);
        check("new_game_idle", K0, 1'b0, 2'd3, 1'b0);

        // Key held through RESET must not hop.
        cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        cycle(1'b0, KU, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, KU, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, KU, 1'b0, 1'b0, 1'b0);
            check($sformatf("held_key_no_hop%0d", i), K0, 1'b0, 2'd3, 1'b0);
        end

        // RESET during DYING: back to IDLE with full lives and no respawn pulse.
        cycle(1'b0, KU, 1'b1, 1'b0, 1'b0);
        check("dying_before_reset", K0, 1'b0, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, KU, 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        cycle(1'b1, KU, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        check("reset_in_dying", K0, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 65; i++) begin
            cycle(1'b1, KU, 1'b0, 1'b0, 1'b0);
            if (reset_position !== 1'b0 || i == 64)
                check($sformatf("no_pulse_after_reset%0d", i), K0, 1'b0, 2'd3, 1'b0);
        end
        cycle(1'b0, K0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, KD, 1'b0, 1'b0, 1'b0);
        check("idle_after_reset", KD, 1'b0, 2'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frog_hop_ctrl.md
# frog_hop_ctrl

Upstream control stage for the frog position register. Converts raw keyboard key levels into discrete, fixed-length hops by driving the position block's `left`/`right`/`up`/`down` inputs for exactly `HOP_TICKS` movement ticks. It also sequences death and respawn: it tracks lives, holds off input during the death delay, and issues the `reset_position` pulse.

## Interface
Parameters:
- `HOP_TICKS`, 8: `timer_done` ticks per hop; 1..255.
- `COOLDOWN_TICKS`, 4: ticks of input lockout after a hop; 0..255.
- `DEATH_TICKS`, 60: ticks spent in the death delay; 1..255.
- `LIVES`, 3: lives at reset or new game; 1..3.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: **synchronous, active-high** reset. The block has one clock.
- `timer_done` in 1: one-cycle movement tick, the same strobe fed to the position block.
- `key_left`, `key_right`, `key_up`, `key_down` in 1 each: key levels, already synchronous to `CLK`.
- `collision` in 1: frog hit a car, level.
- `drown` in 1: frog in water off a log, level.
- `new_game` in 1: one-cycle pulse, accepted only in GAME_OVER.
- `left`, `right`, `up`, `down` out 1 each: direction requests to the position block.
- `reset_position` out 1: one-cycle pulse that returns the frog to the start position.
- `lives` out 2: remaining lives.
- `game_over` out 1: high while in GAME_OVER.

## Operation
- Key edge detect: a 4-bit history register samples the keys every cycle. A press is a 0→1 transition.
- Reset loads the history with all ones, so a key held through reset does not cause a hop.
- Priority when several presses occur in the same cycle: up > down > left > right. Only one direction is latched into `dir`.
- FSM states: IDLE, HOP, COOLDOWN, DYING, RESPAWN, GAME_OVER.
- IDLE:
  - A press latches `dir`, clears `tick_cnt` and moves to HOP.
  - Presses seen in any other state are discarded; they are not queued.
- HOP:
  - The output selected by `dir` is high for the whole state; the other three outputs are low.
  - Each `timer_done` increments `tick_cnt`.
  - At the `timer_done` where `tick_cnt == HOP_TICKS-1`, the FSM moves to COOLDOWN and clears `tick_cnt`.
- COOLDOWN:
  - All direction outputs are low.
  - After `COOLDOWN_TICKS` `timer_done` pulses, the FSM moves to IDLE.
  - If `COOLDOWN_TICKS == 0`, HOP goes straight to IDLE.
- Death:
  - `collision | drown` seen in IDLE, HOP or COOLDOWN moves to DYING.
  - On entry, `lives` decrements, saturating at 0, and `tick_cnt` clears.
  - Death has priority over a key press and over hop completion in the same cycle.
  - `collision` and `drown` are ignored in DYING, RESPAWN and GAME_OVER.
- DYING:
  - Direction outputs are low.
  - After `DEATH_TICKS` `timer_done` pulses: if `lives == 0`, go to GAME_OVER; otherwise go to RESPAWN.
- RESPAWN: `reset_position = 1` for exactly one cycle, then go to IDLE.
- GAME_OVER:
  - `game_over = 1`. All keys are ignored.
  - `new_game` reloads `lives = LIVES` and goes to RESPAWN.
- Outputs are Moore decodes of registered state. There is no combinational path from any input to any output.

## Timing
- Reset values: state IDLE, `lives = LIVES`, `tick_cnt = 0`, `dir = up`, all direction outputs 0, `reset_position = 0`, `game_over = 0`.
- Key rising at edge N: the press is detected at edge N, and the direction output is high from edge N+1.
- The direction output is still high in the cycle where the last `timer_done` is high, so the position block sees exactly `HOP_TICKS` qualifying ticks. It drops at the following edge.
- A `timer_done` in the same cycle as the press edge does not count toward the hop.
- The `collision` edge moves the FSM to DYING at the next clock. Outputs drop in the same cycle `lives` updates.
- RESET mid-hop or mid-death aborts at once, with no `reset_position` pulse. The position block receives its own reset.
- `tick_cnt` is 8 bits; it is compared for equality and never wraps.

## Structure
- Shared package `frog_pkg` holds:
  - `hop_state_t`, an enum of the six states.
  - `dir_t`, an enum: UP, DOWN, LEFT, RIGHT.
  - Constant `LIVES_W = 2`.
- Sub-module `key_edge_detect` contains the 4-bit history register and the priority encoder. It outputs `press_valid` and `press_dir`.
- The FSM and counters stay in `frog_hop_ctrl`.

## Test plan
- Single hop: press `key_up` in IDLE, 8 ticks → `up` high for exactly 8 `timer_done` pulses, then low. IDLE is reached after 4 more ticks.
- Lockout: press `key_left` during HOP(up) and during COOLDOWN → no left hop occurs. A fresh press in IDLE hops left.
- Priority: `key_down` and `key_right` rise in the same cycle → only `down` asserts.
- Death mid-hop: `collision` at tick 3 of a hop → `up` drops next cycle and `lives` goes 3→2. After 60 ticks, `reset_position` pulses for 1 cycle and the FSM returns to IDLE.
- Game over: three `drown` events → `lives = 0`, `game_over = 1` after the last death delay, keys ignored. `new_game` → `lives = 3`, `reset_position` pulse, IDLE.
- Reset: hold `key_up` across RESET → no hop. RESET asserted during DYING → IDLE with `lives = 3` and no `reset_position` pulse.
